// File: rtl/debug_scan_ctrl.sv
// Run/dump sequencer: starts the core, times the run, then streams every RF and DM
// debug location as {is_dm, addr, data} records. Optional build macro: DM_SKIP_ZERO_EN.
module debug_scan_ctrl #(
    parameter int DATA_W   = 8,
    parameter int RF_DEPTH = 4,
    parameter int DM_DEPTH = 16,
    parameter int ADDR_W   = 4,
    parameter int SETTLE   = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              cpu_stopped,
    output logic              cpu_start,
    output logic              dbg_is_dm,
    output logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic              rec_is_dm,
    output logic [ADDR_W-1:0] rec_addr,
    output logic [DATA_W-1:0] rec_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  run_cycles
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = '1;

    typedef enum logic [2:0] {
        IDLE, START, RUN, SETTLE_ST, CAPTURE, EMIT, DONE
    } state_t;

    state_t             state, state_n;
    logic               go_q;
    logic               go_edge;
    logic               run_first;
    logic               ptr_is_dm;
    logic [ADDR_W-1:0]  ptr_addr;
    logic [SET_W-1:0]   settle_cnt;
    logic               scanning;
    logic               last_rf, last_dm, last_entry;
    logic               skip;
    logic               stop_seen;
    logic               sat_next;
    logic               advance;

    assign go_edge    = go & ~go_q;
    assign last_rf    = ptr_addr == ADDR_W'(RF_DEPTH - 1);
    assign last_dm    = ptr_addr == ADDR_W'(DM_DEPTH - 1);
    assign last_entry = ptr_is_dm & last_dm;
    // First RUN cycle sees the halted flag left over from the previous run.
    assign stop_seen  = ~run_first & cpu_stopped;
    assign sat_next   = run_cycles == CNT_TOP - CNT_W'(1);

`ifdef DM_SKIP_ZERO_EN
    assign skip = ptr_is_dm & (dbg_data == '0);
`else
    assign skip = 1'b0;
`endif

    assign advance = ((state == CAPTURE) & skip) | ((state == EMIT) & rec_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (go_edge) state_n = START;
            START:      state_n = RUN;
            RUN:        if (stop_seen || sat_next) state_n = SETTLE_ST;
            SETTLE_ST:  if (settle_cnt == SET_W'(SETTLE - 1)) state_n = CAPTURE;
            CAPTURE: begin
                if (!skip)          state_n = EMIT;
                else if (last_entry) state_n = DONE;
                else                 state_n = SETTLE_ST;
            end
            EMIT: begin
                if (rec_ready) state_n = last_entry ? DONE : SETTLE_ST;
            end
            default:    state_n = IDLE;
        endcase
    end

    assign scanning  = (state == SETTLE_ST) | (state == CAPTURE) | (state == EMIT);
    assign cpu_start = state == START;
    assign busy      = (state != IDLE) & (state != DONE);
    assign done      = state == DONE;
    assign rec_valid = state == EMIT;
    assign dbg_is_dm = scanning & ptr_is_dm;
    assign dbg_addr  = scanning ? ptr_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_q       <= 1'b0;
            run_first  <= 1'b0;
            run_cycles <= '0;
            timeout    <= 1'b0;
            ptr_is_dm  <= 1'b0;
            ptr_addr   <= '0;
            settle_cnt <= '0;
            rec_is_dm  <= 1'b0;
            rec_addr   <= '0;
            rec_data   <= '0;
        end else begin
            go_q <= go;
            if ((state == IDLE || state == DONE) && go_edge) begin
                run_cycles <= '0;
                timeout    <= 1'b0;
                ptr_is_dm  <= 1'b0;
                ptr_addr   <= '0;
            end
            if (state == START) run_first <= 1'b1;
            if (state == RUN) begin
                run_first  <= 1'b0;
                settle_cnt <= '0;
                if (run_cycles != CNT_TOP) run_cycles <= run_cycles + CNT_W'(1);
                if (!stop_seen && sat_next) timeout <= 1'b1;
            end
            if (state == SETTLE_ST) settle_cnt <= settle_cnt + SET_W'(1);
            if (state == CAPTURE) begin
                rec_is_dm <= ptr_is_dm;
                rec_addr  <= ptr_addr;
                rec_data  <= dbg_data;
            end
            if (advance) begin
                settle_cnt <= '0;
                if (!ptr_is_dm && last_rf) begin
                    ptr_is_dm <= 1'b1;
                    ptr_addr  <= '0;
                end else begin
                    ptr_addr  <= ptr_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_debug_scan_ctrl.sv
// Scoreboard bench for debug_scan_ctrl: a core model, a debug memory model and a stalling consumer.
module tb_debug_scan_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CW = 4;
`ifdef DM_SKIP_ZERO_EN
    localparam int EXP6 = 6;
`else
    localparam int EXP6 = 20;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic          cpu_stopped, cpu_start;
    logic          dbg_is_dm;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          rec_valid, rec_ready, rec_is_dm;
    logic [AW-1:0] rec_addr;
    logic [DW-1:0] rec_data;
    logic          busy, done, timeout;
    logic [CW-1:0] run_cycles;

    debug_scan_ctrl #(.DATA_W(DW), .RF_DEPTH(4), .DM_DEPTH(16), .ADDR_W(AW),
                      .SETTLE(2), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .cpu_stopped(cpu_stopped),
        .cpu_start(cpu_start), .dbg_is_dm(dbg_is_dm), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_is_dm(rec_is_dm), .rec_addr(rec_addr), .rec_data(rec_data),
        .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rf [0:3];
    logic [DW-1:0] dm [0:15];
    assign dbg_data = dbg_is_dm ? dm[dbg_addr] : rf[dbg_addr[1:0]];

    // Core model: stale halted flag for one cycle after start, then halts after stop_after cycles.
    int  stop_after = 10;
    bit  active;
    int  ccnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            ccnt   <= 0;
        end else if (cpu_start) begin
            active <= 1'b1;
            ccnt   <= 0;
        end else if (active && ccnt < 100000) begin
            ccnt <= ccnt + 1;
        end
    end
    assign cpu_stopped = !active || ccnt == 0 || ccnt >= stop_after - 1;

    // Consumer: optionally stalls on one DM address for stall_lim cycles.
    bit  stall_en = 1'b0;
    int  stall_addr = 0;
    int  stall_lim = 0;
    int  stall_used;
    logic stall_match;
    assign stall_match = stall_en && rec_valid && rec_is_dm &&
                         rec_addr == AW'(stall_addr) && stall_used < stall_lim;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            stall_used <= 0;
        else if (!stall_en)    stall_used <= 0;
        else if (stall_match)  stall_used <= stall_used + 1;
    end
    assign rec_ready = !stall_match;

    logic [12:0] expq[$];
    int total = 0;
    int bad = 0;
    int starts = 0;
    int nrec = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted record and checks hold-while-stalled.
    bit          prev_stall = 1'b0;
    logic [12:0] prev_rec = '0;
    always @(negedge clk) begin
        if (cpu_start) starts++;
        if (rst_n && prev_stall) begin
            chk("stall valid held", {31'b0, rec_valid}, 32'd1);
            if (rec_valid) chk("stall rec stable", {19'b0, rec_is_dm, rec_addr, rec_data}, {19'b0, prev_rec});
        end
        if (rec_valid && rec_ready) begin
            nrec++;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected record: got %0h expected none", {rec_is_dm, rec_addr, rec_data});
            end else begin
                chk("record", {19'b0, rec_is_dm, rec_addr, rec_data}, {19'b0, expq.pop_front()});
            end
        end
        prev_stall = rst_n && rec_valid && !rec_ready;
        prev_rec   = {rec_is_dm, rec_addr, rec_data};
    end

    function automatic logic [31:0] all_outs();
        return {5'b0, cpu_start, dbg_is_dm, dbg_addr, rec_valid, rec_is_dm, rec_addr,
                rec_data, busy, done, timeout, run_cycles};
    endfunction

    task automatic push_exp();
        for (int i = 0; i < 4; i++) expq.push_back({1'b0, 4'(i), rf[i]});
        for (int i = 0; i < 16; i++) begin
`ifdef DM_SKIP_ZERO_EN
            if (dm[i] != 0)
`endif
            expq.push_back({1'b1, 4'(i), dm[i]});
        end
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("done reached", {31'b0, done}, 32'd1);
    endtask

    task automatic do_run(input int exp_cyc, input bit exp_to, input bit mid_go,
                          input bit keep_go, input int exp_n);
        int s0 = starts;
        int r0 = nrec;
        push_exp();
        @(negedge clk) go = 1'b1;
        @(negedge clk);
        if (!keep_go) go = 1'b0;
        chk("busy after go", {31'b0, busy}, 32'd1);
        chk("timeout cleared", {31'b0, timeout}, 32'd0);
        if (mid_go) begin
            repeat (30) @(negedge clk);
            go = 1'b1;
            @(negedge clk) go = 1'b0;
            chk("busy ignores go", {31'b0, busy}, 32'd1);
        end
        wait_done(3000);
        chk("run_cycles", {28'b0, run_cycles}, exp_cyc);
        chk("timeout", {31'b0, timeout}, {31'b0, exp_to});
        chk("start pulses", starts - s0, 32'd1);
        chk("record count", nrec - r0, exp_n);
        chk("queue drained", expq.size(), 32'd0);
        chk("dbg idle in done", {27'b0, dbg_is_dm, dbg_addr}, 32'd0);
        if (keep_go) begin
            repeat (10) @(negedge clk);
            chk("no restart on held go", {30'b0, done, busy}, 32'd2);
            chk("start pulses held go", starts - s0, 32'd1);
            go = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 8'(8'hA0 + i);
        for (int i = 0; i < 16; i++) dm[i] = 8'((i + 1) * 17);
        repeat (2) @(negedge clk);
        chk("reset outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal run, stop after 10 cycles, free-flowing consumer
        do_run(10, 1'b0, 1'b0, 1'b0, 20);

        // Backpressure on DM3 for 5 cycles
        stall_en = 1'b1; stall_addr = 3; stall_lim = 5;
        do_run(10, 1'b0, 1'b0, 1'b0, 20);
        stall_en = 1'b0;

        // Core never halts: counter saturates at 15 and the dump still happens
        stop_after = 100000;
        do_run(15, 1'b1, 1'b0, 1'b0, 20);
        stop_after = 10;

        // go pulsed mid-scan, then go held high through DONE
        do_run(10, 1'b0, 1'b1, 1'b0, 20);
        do_run(10, 1'b0, 1'b0, 1'b1, 20);
        do_run(10, 1'b0, 1'b0, 1'b0, 20);

        // Reset while DM7 is stalled in EMIT
        stall_en = 1'b1; stall_addr = 7; stall_lim = 1000000;
        for (int i = 0; i < 4; i++) expq.push_back({1'b0, 4'(i), rf[i]});
        for (int i = 0; i < 7; i++) expq.push_back({1'b1, 4'(i), dm[i]});
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        begin
            int n = 0;
            while (!(rec_valid && rec_is_dm && rec_addr == 4'd7) && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        chk("reached DM7", {27'b0, rec_valid, rec_is_dm, rec_addr}, 32'h37);
        #2 rst_n = 1'b0;
        #1 chk("async reset outputs", all_outs(), 32'd0);
        stall_en = 1'b0;
        chk("pre-reset records drained", expq.size(), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle after reset", {29'b0, rec_valid, busy, done}, 32'd0);

        // Sparse DM contents
        for (int i = 0; i < 16; i++) dm[i] = 8'h00;
        dm[2] = 8'h5A;
        dm[9] = 8'hC3;
        do_run(10, 1'b0, 1'b0, 1'b0, EXP6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
